ext_reg_loader: RTL and testbench

Serial front end that lets an off-chip host write the externally controllable register bank.
- Receives a 16-bit frame over a 3-wire serial link (sclk, cs_n, mosi), asynchronous to clk.
- Decodes the target register index from the frame.
- Drives a one-cycle load strobe plus an 8-bit data bus into the bank of 8-bit load-enabled registers directly downstream.

---
 rtl/ext_reg_loader_pkg.sv | 24 ++
 rtl/ext_reg_loader_sync.sv | 32 +++
 rtl/ext_reg_loader.sv | 139 +++++++++++++
 tb/tb_ext_reg_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ext_reg_loader_pkg.sv
// Shared types and frame layout for the external register loader.
// EXT_REG_LOADER_PARITY_EN appends an even-parity bit after the 16-bit frame.
package ext_reg_loader_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_CS} state_e;

`ifdef EXT_REG_LOADER_PARITY_EN
    localparam int FRAME_BITS = 17;
`else
    localparam int FRAME_BITS = 16;
`endif

    // The parity bit, when present, occupies bit 0 and pushes every field up by one.
    localparam int PAR_BITS = FRAME_BITS - 16;
    localparam int W_BIT    = 15 + PAR_BITS;
    localparam int HDR_MSB  = 14 + PAR_BITS;
    localparam int HDR_LSB  = 8 + PAR_BITS;
    localparam int DATA_MSB = 7 + PAR_BITS;
    localparam int DATA_LSB = PAR_BITS;

    localparam int CNT_W = 5;
    localparam logic [7:0] DATA_RST = 8'h00;

endpackage

// File: rtl/ext_reg_loader_sync.sv
// Multi-flop synchronizer with a trailing edge-detect flop.
// RST_VAL sets the idle level so no false edge appears as reset releases.
module ser_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/ext_reg_loader.sv
// Serial host front end: shifts in a frame and strobes one downstream register.
// Build with EXT_REG_LOADER_PARITY_EN for 17-bit frames with even parity.
module ext_reg_loader
    import ext_reg_loader_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ser_sclk,
    input  logic                ser_cs_n,
    input  logic                ser_mosi,
    output logic [NUM_REGS-1:0] load,
    output logic [7:0]          reg_data,
    output logic                busy,
    output logic                frame_err
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    ser_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(ser_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    ser_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(ser_cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    ser_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(ser_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   sh_q, sh_d;
    logic [NUM_REGS-1:0]     load_q, load_d;
    logic [7:0]              data_q, data_d;
    logic                    err_q, err_d;

    logic             wr_flag, idx_ok, par_ok;
    logic [IDX_W-1:0] idx;
    logic [7:0]       frame_data;
    logic             unused_sync;

    assign wr_flag    = sh_q[W_BIT];
    assign idx        = sh_q[HDR_LSB +: IDX_W];
    assign frame_data = sh_q[DATA_MSB:DATA_LSB];
    assign idx_ok     = (int'(idx) < NUM_REGS);

`ifdef EXT_REG_LOADER_PARITY_EN
    assign par_ok = ~^sh_q;
`else
    assign par_ok = 1'b1;
`endif

    assign unused_sync = ^{sclk_lvl, sclk_fall, mosi_rise, mosi_fall, sh_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            load_q  <= '0;
            data_q  <= DATA_RST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            load_q  <= load_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Commit decisions are registered on entry to COMMIT, so load and reg_data
    // are valid together for exactly the COMMIT cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        load_d  = '0;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == FRAME_CNT) begin
                    state_d = COMMIT;
                    if (!par_ok) begin
                        err_d = 1'b1;
                    end else if (wr_flag) begin
                        if (idx_ok) begin
                            load_d = NUM_REGS'(1) << idx;
                            data_d = frame_data;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (sclk_rise) begin
                    sh_d  = {sh_q[FRAME_BITS-2:0], mosi_lvl};
                    cnt_d = cnt_q + CNT_W'(1);
                    // A last-bit rise beats a coincident cs_n rise; WAIT_CS catches the level.
                    if (cs_rise && cnt_q != FRAME_CNT - CNT_W'(1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            COMMIT: state_d = WAIT_CS;
            WAIT_CS: begin
                if (cs_lvl) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign load      = load_q;
    assign reg_data  = data_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = err_q;

endmodule

// File: tb/tb_ext_reg_loader.sv
// Randomized and directed bench for ext_reg_loader against a frame-level model.
module tb_ext_reg_loader;

    localparam int NR    = 3;
    localparam int SS    = 2;
    localparam int HALF  = 8;
    localparam int IDXW  = 2;
`ifdef EXT_REG_LOADER_PARITY_EN
    localparam int FB = 17;
    localparam bit PAR = 1'b1;
`else
    localparam int FB = 16;
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ser_sclk = 1'b0;
    logic          ser_cs_n = 1'b1;
    logic          ser_mosi = 1'b0;
    logic [NR-1:0] load;
    logic [7:0]    reg_data;
    logic          busy;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_data = 8'h00;
    int   pulses = 0;
    int   multihot = 0;
    logic [7:0] last_data = 8'h00;

    ext_reg_loader #(.NUM_REGS(NR), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .ser_sclk(ser_sclk), .ser_cs_n(ser_cs_n),
        .ser_mosi(ser_mosi), .load(load), .reg_data(reg_data), .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load != '0) begin
            pulses    <= pulses + 1;
            last_data <= reg_data;
            if ($countones(load) != 1) multihot <= multihot + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [16:0] mk(input logic [15:0] f);
        if (PAR) return {f, ^f};
        return {1'b0, f};
    endfunction

    task automatic send(input logic [16:0] fr, input int nsend, input int extra,
                        input logic [NR-1:0] exp_ld);
        ser_cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nsend; i++) begin
            ser_mosi = fr[FB-1-i];
            wait_clk(HALF);
            ser_sclk = 1'b1;
            if (i == FB - 1) begin
                wait_clk(SS + 1);
                chk("lat_early", 32'(load), 32'(0));
                wait_clk(1);
                chk("lat_load", 32'(load), 32'(exp_ld));
                wait_clk(HALF - SS - 2);
            end else begin
                wait_clk(HALF);
            end
            ser_sclk = 1'b0;
            if (i == 0) begin
                chk("busy_mid", 32'(busy), 32'(1));
                chk("err_clr", 32'(frame_err), 32'(0));
            end
        end
        for (int e = 0; e < extra; e++) begin
            wait_clk(HALF);
            ser_sclk = 1'b1;
            wait_clk(HALF);
            ser_sclk = 1'b0;
        end
        wait_clk(HALF);
        ser_cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic run_frame(input logic [15:0] f, input int nsend, input int extra, input bit flip);
        logic [16:0]   fr;
        logic [NR-1:0] exp_ld;
        bit            exp_err;
        int            idx, p0;
        fr = mk(f);
        if (flip) fr[0] = ~fr[0];
        idx = int'(f[14:8]) % (1 << IDXW);
        exp_ld = '0;
        exp_err = 1'b0;
        if (nsend < FB) exp_err = 1'b1;
        else if (flip) exp_err = 1'b1;
        else if (f[15]) begin
            if (idx >= NR) exp_err = 1'b1;
            else exp_ld[idx] = 1'b1;
        end
        p0 = pulses;
        send(fr, nsend, extra, exp_ld);
        if (exp_ld != '0) model_data = f[7:0];
        chk("pulses", 32'(pulses - p0), 32'(exp_ld != '0));
        if (exp_ld != '0) chk("ld_data", 32'(last_data), 32'(f[7:0]));
        chk("reg_data", 32'(reg_data), 32'(model_data));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        chk("busy_end", 32'(busy), 32'(0));
        chk("multihot", 32'(multihot), 32'(0));
    endtask

    initial begin
        logic [16:0] fr;
        wait_clk(3);
        chk("rst_load", 32'(load), 32'(0));
        chk("rst_data", 32'(reg_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(frame_err), 32'(0));
        reset = 1'b1;
        wait_clk(4);

        run_frame(16'h8137, FB, 0, 1'b0);
        run_frame(16'h0255, FB, 0, 1'b0);
        run_frame(16'h83AA, FB, 0, 1'b0);
        ser_cs_n = 1'b0;
        wait_clk(6);
        chk("cs_fall_clr", 32'(frame_err), 32'(0));
        chk("cs_fall_busy", 32'(busy), 32'(1));
        ser_cs_n = 1'b1;
        wait_clk(6);
        chk("empty_frame_err", 32'(frame_err), 32'(1));
        run_frame(16'h80FF, 9, 0, 1'b0);
        run_frame(16'h80C3, FB, 0, 1'b0);
        run_frame(16'h8011, FB, 4, 1'b0);

        fr = mk(16'h8142);
        ser_cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 10; i++) begin
            ser_mosi = fr[FB-1-i];
            wait_clk(HALF);
            ser_sclk = 1'b1;
            wait_clk(HALF);
            ser_sclk = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_load", 32'(load), 32'(0));
        chk("mid_rst_data", 32'(reg_data), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_err", 32'(frame_err), 32'(0));
        model_data = 8'h00;
        ser_cs_n = 1'b1;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(4);
        run_frame(16'h8142, FB, 0, 1'b0);

`ifdef EXT_REG_LOADER_PARITY_EN
        run_frame(16'h8137, FB, 0, 1'b0);
        run_frame(16'h8137, FB, 0, 1'b1);
`endif

        for (int n = 0; n < 30; n++) begin
            logic [15:0] f;
            int ns, ex;
            bit fl;
            f  = 16'($urandom);
            ns = ($urandom % 6 == 0) ? int'($urandom_range(0, FB - 1)) : FB;
            ex = (ns == FB) ? int'($urandom_range(0, 3)) : 0;
            fl = PAR ? bit'($urandom % 4 == 0) : 1'b0;
            run_frame(f, ns, ex, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
